chain_cost_min: RTL

CHAIN_COST_MIN -- requirements
Module: chain_cost_min

---
 rtl/chain_pkg.sv | 26 ++
 rtl/chain_cost_mac.sv | 75 +++++++
 rtl/chain_cost_min.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/chain_pkg.sv
`default_nettype none
// ============================================================================
// Module      : chain_pkg
// Description : Shared definitions for the matrix-chain cost minimiser.
//               Holds the width defaults, the cost saturation constant and
//               the per-stage control payload carried down the pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
package chain_pkg;

  localparam int unsigned C_IDX_W_DEF  = 8;
  localparam int unsigned C_DIM_W_DEF  = 16;
  localparam int unsigned C_COST_W_DEF = 32;

  // Saturated cost is all-ones; users replicate bit 0 to any COST_W.
  localparam logic [C_COST_W_DEF-1:0] C_COST_SAT = '1;

  // Control bits that travel alongside each tuple through S1 and S2.
  typedef struct packed {
    logic vld;   // stage holds a live tuple
    logic last;  // tuple closes its (i, j) group
    logic diag;  // i == j, candidate is forced to zero
  } stage_ctl_t;

endpackage
`default_nettype wire

// File: rtl/chain_cost_mac.sv
`default_nettype none
// ============================================================================
// Module      : chain_cost_mac
// Description : S2 arithmetic of the chain cost pipeline. Registers the full
//               width product p[i]*p[k+1]*p[j+1] and the partial sum
//               m[i][k]+m[k+1][j], then presents the saturated candidate
//               combinationally for the S3 compare.
// Revision    : 1.0 - initial release
// Ports       : clk, rst    - clock, synchronous active-high reset
//               i_en        - pipeline advance (low freezes the registers)
//               i_ma, i_mb  - cost read data for the tuple in S1
//               i_p0..i_p2  - dimension read data for the tuple in S1
//               i_zero      - diagonal flag of the tuple now in S2
//               o_cand      - saturated candidate of the tuple in S2
// ============================================================================
module chain_cost_mac
  import chain_pkg::*;
#(
  parameter int DIM_W  = C_DIM_W_DEF,
  parameter int COST_W = C_COST_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_en,
  input  logic [COST_W-1:0] i_ma,
  input  logic [COST_W-1:0] i_mb,
  input  logic [DIM_W-1:0]  i_p0,
  input  logic [DIM_W-1:0]  i_p1,
  input  logic [DIM_W-1:0]  i_p2,
  input  logic              i_zero,
  output logic [COST_W-1:0] o_cand
);

  localparam int C_PW = 3 * DIM_W;
  localparam int C_SW = COST_W + 2;
  // Compare width large enough to hold both the product and a cost.
  localparam int C_EW = (C_PW > COST_W) ? C_PW : COST_W;
  localparam logic [COST_W-1:0] C_SAT = {COST_W{C_COST_SAT[0]}};

  logic [C_PW-1:0] r_prod;
  logic [C_SW-1:0] r_part;
  logic [C_PW-1:0] w_prod;
  logic [C_EW-1:0] w_prod_e;
  logic            w_prod_big;
  logic [C_SW-1:0] w_sum;

  assign w_prod = C_PW'(i_p0) * C_PW'(i_p1) * C_PW'(i_p2);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prod <= '0;
      r_part <= '0;
    end else if (i_en) begin
      r_prod <= w_prod;
      r_part <= C_SW'(i_ma) + C_SW'(i_mb);
    end
  end

  // A product above the cost range saturates on its own; otherwise only its
  // low COST_W bits can contribute and the COST_W+2 bit sum cannot wrap.
  assign w_prod_e   = C_EW'(r_prod);
  assign w_prod_big = (w_prod_e > C_EW'(C_SAT));
  assign w_sum      = r_part + C_SW'(w_prod_e[COST_W-1:0]);

  always_comb begin
    o_cand = w_sum[COST_W-1:0];
    if (i_zero) begin
      o_cand = '0;
    end else if (w_prod_big || (w_sum > C_SW'(C_SAT))) begin
      o_cand = C_SAT;
    end
  end

endmodule
`default_nettype wire

// File: rtl/chain_cost_min.sv
`default_nettype none
// ============================================================================
// Module      : chain_cost_min
// Description : Three-stage pipeline that forms the matrix-chain split cost
//               m[i][k] + m[k+1][j] + p[i]*p[k+1]*p[j+1] for every accepted
//               (i, j, k) tuple, keeps the running minimum per (i, j) group
//               and emits m[i][j] with its argmin on the last k.
//               Optional feature macro: SPLIT_TRACK_EN (argmin tracking;
//               without it wr_split is tied to zero).
// Revision    : 1.0 - initial release
// Ports       : clk, reset           - clock, synchronous active-high reset
//               ir, jr, kr, last_k   - tuple from the index iterator
//               idx_valid/idx_ready  - tuple handshake
//               ma_*, mb_*, p_*      - cost/dimension table reads (1 cycle)
//               wr_valid/wr_ready    - result handshake
//               wr_i, wr_j, wr_cost, wr_split - result payload
// ============================================================================
module chain_cost_min
  import chain_pkg::*;
#(
  parameter int IDX_W  = C_IDX_W_DEF,
  parameter int DIM_W  = C_DIM_W_DEF,
  parameter int COST_W = C_COST_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [IDX_W-1:0]  ir,
  input  logic [IDX_W-1:0]  jr,
  input  logic [IDX_W-1:0]  kr,
  input  logic              last_k,
  input  logic              idx_valid,
  output logic              idx_ready,
  output logic [IDX_W-1:0]  ma_addr_i,
  output logic [IDX_W-1:0]  ma_addr_j,
  output logic [IDX_W-1:0]  mb_addr_i,
  output logic [IDX_W-1:0]  mb_addr_j,
  input  logic [COST_W-1:0] ma_data,
  input  logic [COST_W-1:0] mb_data,
  output logic [IDX_W-1:0]  p_addr0,
  output logic [IDX_W-1:0]  p_addr1,
  output logic [IDX_W-1:0]  p_addr2,
  input  logic [DIM_W-1:0]  p_data0,
  input  logic [DIM_W-1:0]  p_data1,
  input  logic [DIM_W-1:0]  p_data2,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [IDX_W-1:0]  wr_i,
  output logic [IDX_W-1:0]  wr_j,
  output logic [COST_W-1:0] wr_cost,
  output logic [IDX_W-1:0]  wr_split
);

  logic              w_adv;
  logic              w_accept;
  logic [IDX_W-1:0]  w_ai, w_aj, w_ak;
  logic [COST_W-1:0] w_cand;
  logic              w_take;
  logic [COST_W-1:0] w_new_min;

  stage_ctl_t        r_s1, r_s2;
  logic [IDX_W-1:0]  r_s1_i, r_s1_j, r_s1_k;
  logic [IDX_W-1:0]  r_s2_i, r_s2_j;
  logic [COST_W-1:0] r_min;
  logic              r_in_group;
  logic              r_wr_valid;
  logic [IDX_W-1:0]  r_wr_i, r_wr_j;
  logic [COST_W-1:0] r_wr_cost;

  // A pending result that is not being taken freezes every stage.
  assign w_adv     = !(r_wr_valid && !wr_ready);
  assign idx_ready = w_adv && !reset;
  assign w_accept  = idx_valid && idx_ready;

  // While frozen, keep re-reading the tables for the tuple parked in S1 so
  // its read data is still on the buses in the cycle the pipeline resumes.
  assign w_ai = w_adv ? ir : r_s1_i;
  assign w_aj = w_adv ? jr : r_s1_j;
  assign w_ak = w_adv ? kr : r_s1_k;

  assign ma_addr_i = w_ai;
  assign ma_addr_j = w_ak;
  assign mb_addr_i = w_ak + IDX_W'(1);
  assign mb_addr_j = w_aj;
  assign p_addr0   = w_ai;
  assign p_addr1   = w_ak + IDX_W'(1);
  assign p_addr2   = w_aj + IDX_W'(1);

  // S1: tuple metadata, aligned with the table read data.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1   <= '0;
      r_s1_i <= '0;
      r_s1_j <= '0;
      r_s1_k <= '0;
    end else if (w_adv) begin
      r_s1.vld  <= w_accept;
      r_s1.last <= last_k;
      r_s1.diag <= (ir == jr);
      r_s1_i    <= ir;
      r_s1_j    <= jr;
      r_s1_k    <= kr;
    end
  end

  // S2: metadata alongside the registered product / partial sum.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s2   <= '0;
      r_s2_i <= '0;
      r_s2_j <= '0;
    end else if (w_adv) begin
      r_s2   <= r_s1;
      r_s2_i <= r_s1_i;
      r_s2_j <= r_s1_j;
    end
  end

  chain_cost_mac #(
    .DIM_W  (DIM_W),
    .COST_W (COST_W)
  ) u_mac (
    .clk    (clk),
    .rst    (reset),
    .i_en   (w_adv),
    .i_ma   (ma_data),
    .i_mb   (mb_data),
    .i_p0   (p_data0),
    .i_p1   (p_data1),
    .i_p2   (p_data2),
    .i_zero (r_s2.diag),
    .o_cand (w_cand)
  );

  // S3: first tuple of a group loads, later ones replace only when strictly
  // smaller so the earliest k wins ties.
  always_comb begin
    w_take    = !r_in_group || (w_cand < r_min);
    w_new_min = w_take ? w_cand : r_min;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_min      <= '0;
      r_in_group <= 1'b0;
      r_wr_valid <= 1'b0;
      r_wr_i     <= '0;
      r_wr_j     <= '0;
      r_wr_cost  <= '0;
    end else if (w_adv) begin
      r_wr_valid <= r_s2.vld && r_s2.last;
      if (r_s2.vld) begin
        r_min      <= w_new_min;
        r_in_group <= !r_s2.last;
        if (r_s2.last) begin
          r_wr_i    <= r_s2_i;
          r_wr_j    <= r_s2_j;
          r_wr_cost <= w_new_min;
        end
      end
    end
  end

`ifdef SPLIT_TRACK_EN
  logic [IDX_W-1:0] r_s2_k;
  logic [IDX_W-1:0] r_arg;
  logic [IDX_W-1:0] r_wr_split;
  logic [IDX_W-1:0] w_new_arg;

  assign w_new_arg = w_take ? r_s2_k : r_arg;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s2_k     <= '0;
      r_arg      <= '0;
      r_wr_split <= '0;
    end else if (w_adv) begin
      r_s2_k <= r_s1_k;
      if (r_s2.vld) begin
        r_arg <= w_new_arg;
        if (r_s2.last) begin
          r_wr_split <= w_new_arg;
        end
      end
    end
  end

  assign wr_split = r_wr_split;
`else
  assign wr_split = '0;
`endif

  assign wr_valid = r_wr_valid;
  assign wr_i     = r_wr_i;
  assign wr_j     = r_wr_j;
  assign wr_cost  = r_wr_cost;

endmodule
`default_nettype wire
